// File: rtl/cpc_cfg_write_filter.sv
// cpc_cfg_write_filter
// Front end of the CPC RAM expansion bank-select register. Registers the Z80
// edge-connector bus on CLK, recognises memory-configuration I/O writes
// (A15=0, IOREQ_B=0, WR_B=0, D7:D6=11) that hold for FILTER_CYCLES sampled
// edges, accepts at most one per bus cycle, and offers the captured byte to
// the bank register through a valid/ack handshake with sticky overrun.
//
// Optional build macro INTACK_FILTER_EN: when defined, a write also requires
// M1_B=1, so interrupt-acknowledge cycles (IOREQ_B and M1_B both low) never
// capture. When undefined, M1_B is registered but has no effect.

module cpc_cfg_write_filter #(
  parameter int FILTER_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RESET_B,
  input  logic       A15,
  input  logic       IOREQ_B,
  input  logic       WR_B,
  input  logic       M1_B,
  input  logic [7:0] D,
  input  logic       cfg_ack,
  output logic       cfg_valid,
  output logic [7:0] cfg_data,
  output logic       cfg_ovf,
  output logic       busy
);

  // Filter length held in the 3-bit counter domain; out-of-range values are
  // clamped into 1..7 so the counter can always reach its target.
  localparam logic [2:0] N_CNT = (FILTER_CYCLES < 1) ? 3'd1 :
                                 (FILTER_CYCLES > 7) ? 3'd7 :
                                 3'(FILTER_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  logic       a15_q;
  logic       ioreq_b_q;
  logic       wr_b_q;
  logic       m1_b_q;
  logic [7:0] d_q;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;
  logic       qual;
  logic       capture;

  // Input register: every decision below is taken on these sampled copies.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      a15_q     <= 1'b1;
      ioreq_b_q <= 1'b1;
      wr_b_q    <= 1'b1;
      m1_b_q    <= 1'b1;
      d_q       <= 8'h00;
    end else begin
      a15_q     <= A15;
      ioreq_b_q <= IOREQ_B;
      wr_b_q    <= WR_B;
      m1_b_q    <= M1_B;
      d_q       <= D;
    end
  end

  // Memory-configuration write seen on the sampled bus.
`ifdef INTACK_FILTER_EN
  assign qual = !a15_q && !ioreq_b_q && !wr_b_q && d_q[7] && d_q[6] && m1_b_q;
`else
  logic m1_unused;
  assign m1_unused = m1_b_q;
  assign qual = !a15_q && !ioreq_b_q && !wr_b_q && d_q[7] && d_q[6];
`endif

  // State and run-length registers.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, saturating run count and the one-cycle capture strobe.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (qual) begin
          cnt_nxt = 3'd1;
          if (N_CNT == 3'd1) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end else begin
            state_nxt = QUAL;
          end
        end else begin
          cnt_nxt = 3'd0;
        end
      end
      QUAL: begin
        if (qual) begin
          cnt_nxt = (cnt >= N_CNT) ? N_CNT : cnt + 3'd1;
          if (cnt_nxt == N_CNT) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end else begin
          cnt_nxt   = 3'd0;
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (ioreq_b_q) begin
          cnt_nxt   = 3'd0;
          state_nxt = IDLE;
        end
      end
      default: begin
        cnt_nxt   = 3'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Output byte and handshake; a capture wins over a same-edge ack.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      cfg_valid <= 1'b0;
      cfg_data  <= 8'h00;
      cfg_ovf   <= 1'b0;
    end else if (capture) begin
      cfg_valid <= 1'b1;
      cfg_data  <= d_q;
      if (cfg_valid && !cfg_ack) begin
        cfg_ovf <= 1'b1;
      end else if (cfg_valid && cfg_ack) begin
        cfg_ovf <= 1'b0;
      end
    end else if (cfg_valid && cfg_ack) begin
      cfg_valid <= 1'b0;
      cfg_ovf   <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_cpc_cfg_write_filter.sv
// Bench for cpc_cfg_write_filter (FILTER_CYCLES=2): a table of directed
// vectors, reset corner cases, then randomized bus traffic compared against a
// run-length reference model. Honours INTACK_FILTER_EN when it is defined.

module tb_cpc_cfg_write_filter;

  localparam int N = 2;

  logic       clk;
  logic       reset_b;
  logic       a15;
  logic       ioreq_b;
  logic       wr_b;
  logic       m1_b;
  logic [7:0] d;
  logic       cfg_ack;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_ovf;
  logic       busy;

  int checks = 0;
  int errors = 0;

  cpc_cfg_write_filter #(.FILTER_CYCLES(N)) dut (
    .CLK       (clk),
    .RESET_B   (reset_b),
    .A15       (a15),
    .IOREQ_B   (ioreq_b),
    .WR_B      (wr_b),
    .M1_B      (m1_b),
    .D         (d),
    .cfg_ack   (cfg_ack),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ovf   (cfg_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the pins the DUT saw last edge, the length of the
  // current run of qualifying samples, and whether this I/O cycle already
  // delivered its byte.
  logic       p_a15, p_ioreq, p_wr, p_m1;
  logic [7:0] p_d;
  int         m_run;
  bit         m_done;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ovf;
  logic       m_busy;

  function automatic bit busWrite(input logic a15_v, input logic ioreq_v,
                                  input logic wr_v, input logic m1_v,
                                  input logic [7:0] d_v);
`ifdef INTACK_FILTER_EN
    return !a15_v && !ioreq_v && !wr_v && d_v[7] && d_v[6] && m1_v;
`else
    return !a15_v && !ioreq_v && !wr_v && d_v[7] && d_v[6];
`endif
  endfunction

  task automatic modelReset();
    p_a15 = 1'b1; p_ioreq = 1'b1; p_wr = 1'b1; p_m1 = 1'b1; p_d = 8'h00;
    m_run = 0; m_done = 1'b0;
    m_valid = 1'b0; m_data = 8'h00; m_ovf = 1'b0; m_busy = 1'b0;
  endtask

  task automatic modelStep();
    bit cap;
    if (p_ioreq) m_done = 1'b0;
    if (busWrite(p_a15, p_ioreq, p_wr, p_m1, p_d)) m_run++;
    else m_run = 0;
    cap = (m_run == N) && !m_done;
    if (cap) begin
      m_done = 1'b1;
      if (m_valid && !cfg_ack) m_ovf = 1'b1;
      else if (m_valid && cfg_ack) m_ovf = 1'b0;
      m_valid = 1'b1;
      m_data  = p_d;
    end else if (m_valid && cfg_ack) begin
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end
    m_busy = m_done || (m_run >= 1 && m_run < N);
    p_a15 = a15; p_ioreq = ioreq_b; p_wr = wr_b; p_m1 = m1_b; p_d = d;
  endtask

  // Drive one cycle of bus inputs, advance past the rising edge, and stop
  // on the falling edge where outputs are compared.
  task automatic applyStimulus(input logic a15_v, input logic ioreq_v,
                               input logic wr_v, input logic m1_v,
                               input logic [7:0] d_v, input logic ack_v);
    a15 = a15_v; ioreq_b = ioreq_v; wr_b = wr_v; m1_b = m1_v; d = d_v;
    cfg_ack = ack_v;
    @(posedge clk);
    if (reset_b) modelStep();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic ev,
                             input logic [7:0] ed, input logic eo,
                             input logic eb);
    checks++;
    if (cfg_valid !== ev) begin
      errors++;
      $display("[TB] FAIL %s cfg_valid: got %b want %b", tag, cfg_valid, ev);
    end
    checks++;
    if (cfg_data !== ed) begin
      errors++;
      $display("[TB] FAIL %s cfg_data: got %02h want %02h", tag, cfg_data, ed);
    end
    checks++;
    if (cfg_ovf !== eo) begin
      errors++;
      $display("[TB] FAIL %s cfg_ovf: got %b want %b", tag, cfg_ovf, eo);
    end
    checks++;
    if (busy !== eb) begin
      errors++;
      $display("[TB] FAIL %s busy: got %b want %b", tag, busy, eb);
    end
  endtask

  typedef struct {
    logic       a15, ioreq, wr, m1;
    logic [7:0] d;
    logic       ack;
    logic       valid;
    logic [7:0] data;
    logic       ovf;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void addRaw(input logic a15_v, input logic io_v,
                                 input logic wr_v, input logic m1_v,
                                 input logic [7:0] d_v, input logic ack_v,
                                 input logic ev, input logic [7:0] ed,
                                 input logic eo, input logic eb);
    vec_t v;
    v.a15 = a15_v; v.ioreq = io_v; v.wr = wr_v; v.m1 = m1_v; v.d = d_v;
    v.ack = ack_v; v.valid = ev; v.data = ed; v.ovf = eo; v.busy = eb;
    vecs.push_back(v);
  endfunction

  function automatic void addQual(input logic [7:0] d_v, input logic ack_v,
                                  input logic ev, input logic [7:0] ed,
                                  input logic eo, input logic eb);
    addRaw(1'b0, 1'b0, 1'b0, 1'b1, d_v, ack_v, ev, ed, eo, eb);
  endfunction

  function automatic void addIdle(input logic ack_v, input logic ev,
                                  input logic [7:0] ed, input logic eo,
                                  input logic eb);
    addRaw(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, ack_v, ev, ed, eo, eb);
  endfunction

  initial begin
    // Write 0xC4 held four edges; D changes during HOLD; ack on e5.
    addQual(8'hC4, 0, 0, 8'h00, 0, 0);
    addQual(8'hC4, 0, 0, 8'h00, 0, 1);
    addQual(8'hC4, 0, 1, 8'hC4, 0, 1);
    addQual(8'hCF, 0, 1, 8'hC4, 0, 1);
    addIdle(1, 0, 8'hC4, 0, 1);
    addIdle(0, 0, 8'hC4, 0, 0);
    // Single-edge glitch.
    addQual(8'hC4, 0, 0, 8'hC4, 0, 0);
    addIdle(0, 0, 8'hC4, 0, 1);
    addIdle(0, 0, 8'hC4, 0, 0);
    // Non-matching writes.
    for (int i = 0; i < 3; i++) addRaw(0, 0, 0, 1, 8'h84, 0, 0, 8'hC4, 0, 0);
    for (int i = 0; i < 3; i++) addRaw(1, 0, 0, 1, 8'hC4, 0, 0, 8'hC4, 0, 0);
    for (int i = 0; i < 3; i++) addRaw(0, 1, 0, 1, 8'hC4, 0, 0, 8'hC4, 0, 0);
    // 0xC1 then 0xC7 without ack -> overrun; ack clears; stray ack ignored.
    addQual(8'hC1, 0, 0, 8'hC4, 0, 0);
    addQual(8'hC1, 0, 0, 8'hC4, 0, 1);
    addQual(8'hC1, 0, 1, 8'hC1, 0, 1);
    addIdle(0, 1, 8'hC1, 0, 1);
    addIdle(0, 1, 8'hC1, 0, 0);
    addQual(8'hC7, 0, 1, 8'hC1, 0, 0);
    addQual(8'hC7, 0, 1, 8'hC1, 0, 1);
    addQual(8'hC7, 0, 1, 8'hC7, 1, 1);
    addIdle(0, 1, 8'hC7, 1, 1);
    addIdle(0, 1, 8'hC7, 1, 0);
    addIdle(1, 0, 8'hC7, 0, 0);
    addIdle(1, 0, 8'hC7, 0, 0);
    // 0xC2, 0xC3 (overrun), then 0xC5 captured on the same edge as an ack.
    addQual(8'hC2, 0, 0, 8'hC7, 0, 0);
    addQual(8'hC2, 0, 0, 8'hC7, 0, 1);
    addQual(8'hC2, 0, 1, 8'hC2, 0, 1);
    addIdle(0, 1, 8'hC2, 0, 1);
    addIdle(0, 1, 8'hC2, 0, 0);
    addQual(8'hC3, 0, 1, 8'hC2, 0, 0);
    addQual(8'hC3, 0, 1, 8'hC2, 0, 1);
    addQual(8'hC3, 0, 1, 8'hC3, 1, 1);
    addIdle(0, 1, 8'hC3, 1, 1);
    addIdle(0, 1, 8'hC3, 1, 0);
    addQual(8'hC5, 0, 1, 8'hC3, 1, 0);
    addQual(8'hC5, 0, 1, 8'hC3, 1, 1);
    addQual(8'hC5, 1, 1, 8'hC5, 0, 1);
    addIdle(0, 1, 8'hC5, 0, 1);
    addIdle(0, 1, 8'hC5, 0, 0);
    addIdle(1, 0, 8'hC5, 0, 0);
    // Interrupt-acknowledge shaped cycle with D=0xFF for five edges.
`ifdef INTACK_FILTER_EN
    for (int i = 0; i < 5; i++) addRaw(0, 0, 0, 0, 8'hFF, 0, 0, 8'hC5, 0, 0);
    addIdle(0, 0, 8'hC5, 0, 0);
    addIdle(0, 0, 8'hC5, 0, 0);
    addIdle(1, 0, 8'hC5, 0, 0);
`else
    addRaw(0, 0, 0, 0, 8'hFF, 0, 0, 8'hC5, 0, 0);
    addRaw(0, 0, 0, 0, 8'hFF, 0, 0, 8'hC5, 0, 1);
    addRaw(0, 0, 0, 0, 8'hFF, 0, 1, 8'hFF, 0, 1);
    addRaw(0, 0, 0, 0, 8'hFF, 0, 1, 8'hFF, 0, 1);
    addRaw(0, 0, 0, 0, 8'hFF, 0, 1, 8'hFF, 0, 1);
    addIdle(0, 1, 8'hFF, 0, 1);
    addIdle(0, 1, 8'hFF, 0, 0);
    addIdle(1, 0, 8'hFF, 0, 0);
`endif

    // Power-on reset.
    a15 = 1'b1; ioreq_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1; d = 8'h00;
    cfg_ack = 1'b0;
    reset_b = 1'b0;
    modelReset();
    @(negedge clk);
    checkOutput("reset", 0, 8'h00, 0, 0);
    reset_b = 1'b1;

    $display("[TB] directed table: %0d vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].a15, vecs[i].ioreq, vecs[i].wr, vecs[i].m1,
                    vecs[i].d, vecs[i].ack);
      checkOutput($sformatf("vec%0d", i), vecs[i].valid, vecs[i].data,
                  vecs[i].ovf, vecs[i].busy);
    end

    // Reset pulsed during HOLD with the write still on the bus.
    $display("[TB] reset during HOLD");
    applyStimulus(0, 0, 0, 1, 8'hC9, 0);
    applyStimulus(0, 0, 0, 1, 8'hC9, 0);
    applyStimulus(0, 0, 0, 1, 8'hC9, 0);
    checkOutput("hold_cap", 1, 8'hC9, 0, 1);
    applyStimulus(0, 0, 0, 1, 8'hC9, 0);
    checkOutput("hold_wait", 1, 8'hC9, 0, 1);
    #2 reset_b = 1'b0;
    modelReset();
    #1 checkOutput("hold_async_rst", 0, 8'h00, 0, 0);
    @(negedge clk);
    checkOutput("hold_in_rst", 0, 8'h00, 0, 0);
    reset_b = 1'b1;
    applyStimulus(0, 0, 0, 1, 8'hC9, 0);
    checkOutput("requal_e1", 0, 8'h00, 0, 0);
    applyStimulus(0, 0, 0, 1, 8'hC9, 0);
    checkOutput("requal_e2", 0, 8'h00, 0, 1);
    applyStimulus(0, 0, 0, 1, 8'hC9, 0);
    checkOutput("requal_e3", 1, 8'hC9, 0, 1);
    applyStimulus(1, 1, 1, 1, 8'h00, 1);
    checkOutput("requal_ack", 0, 8'hC9, 0, 1);
    applyStimulus(1, 1, 1, 1, 8'h00, 0);
    checkOutput("requal_idle", 0, 8'hC9, 0, 0);

    // Reset pulsed mid-QUAL: the partial write must not be captured.
    $display("[TB] reset during QUAL");
    applyStimulus(0, 0, 0, 1, 8'hCA, 0);
    checkOutput("qual_e1", 0, 8'hC9, 0, 0);
    applyStimulus(0, 0, 0, 1, 8'hCA, 0);
    checkOutput("qual_e2", 0, 8'hC9, 0, 1);
    #2 reset_b = 1'b0;
    modelReset();
    #1 checkOutput("qual_async_rst", 0, 8'h00, 0, 0);
    @(negedge clk);
    reset_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 1, 1, 8'h00, 0);
      checkOutput($sformatf("qual_after%0d", i), 0, 8'h00, 0, 0);
    end

    // Randomized bus traffic against the reference model.
    $display("[TB] random traffic");
    for (int seg = 0; seg < 600; seg++) begin
      logic       ra15, rio, rwr, rm1;
      logic [7:0] rd;
      int         len;
      if ($urandom_range(0, 9) < 6) begin
        ra15 = 1'b0; rio = 1'b0; rwr = 1'b0;
        rm1  = ($urandom_range(0, 7) != 0);
        rd   = {2'b11, 6'($urandom)};
      end else begin
        ra15 = 1'($urandom); rio = 1'($urandom); rwr = 1'($urandom);
        rm1  = 1'($urandom); rd = 8'($urandom);
      end
      len = $urandom_range(1, 5);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 7) == 0) rd = 8'($urandom);
        if ($urandom_range(0, 9) == 0) rwr = ~rwr;
        applyStimulus(ra15, rio, rwr, rm1, rd, ($urandom_range(0, 3) == 0));
        checkOutput($sformatf("rand%0d.%0d", seg, c), m_valid, m_data,
                    m_ovf, m_busy);
      end
      if ($urandom_range(0, 99) == 0) begin
        #2 reset_b = 1'b0;
        modelReset();
        #1 checkOutput($sformatf("rand_rst%0d", seg), 0, 8'h00, 0, 0);
        @(negedge clk);
        reset_b = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
